conv_layer_seq: RTL and testbench
=================================

CONV_LAYER_SEQ -- requirements
Module: conv_layer_seq

Interface
REQ-001 SHALL have parameter SIZE_address_pix, default 13, width of pixel-memory addresses.
REQ-002 SHALL have parameter SIZE_address_wei, default 13, width of weight-memory addresses.
REQ-003 SHALL have parameter TIMEOUT_W, default 16, width of the per-pass watchdog counter.
REQ-004 SHALL have ports as follows; one clock; reset asynchronous, active-low.
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin one layer; sampled only in IDLE
- abort  in  1  cancel the layer in progress
- n_in  in  4  input channels minus 1 (0..15)
- n_filt  in  3  filters minus 1 (0..7), also drives filt
- matrix2  in  10  pixels per feature map (channel stride)
- base_p  in  SIZE_address_pix  first input-map address
- base_w  in  SIZE_address_wei  first kernel-word address
- base_zap  in  SIZE_address_pix  first output-map address
- STOP  in  1  convolution pass complete, from the conv engine
- conv_en  out  1  enable for the conv engine
- memstartp, memstartzap  out  SIZE_address_pix  pass start addresses
- memstartw  out  SIZE_address_wei  pass kernel address
- lvl  out  4  current input-channel index
- num  out  3  current filter index
- filt  out  3  registered copy of n_filt
- bias  out  1  last channel of the current filter: finalise, ReLU, write back
- busy, done, timeout_err  out  1  status

Function
REQ-005 SHALL register n_in, n_filt, matrix2, base_p, base_w and base_zap when start is accepted. SHALL ignore changes to these inputs until the next accepted start.
REQ-006 SHALL implement the states IDLE, SETUP, RUN, NEXT and FIN.
REQ-007 In IDLE, start=1 SHALL clear lvl and num and move to SETUP. A start that arrives in any other state SHALL be ignored.
REQ-008 SETUP SHALL last one cycle. It SHALL load the address outputs and move to RUN. conv_en SHALL rise on the cycle after SETUP.
REQ-009 In SETUP the address outputs SHALL be:
- memstartp = base_p + lvl*matrix2
- memstartw = base_w + num*(n_in+1) + lvl
- memstartzap = base_zap + num*matrix2
All three SHALL be computed modulo their port width, with silent wrap-around.
REQ-010 bias SHALL be 1 exactly when lvl == n_in. It SHALL be valid from SETUP through the end of RUN.
REQ-011 In RUN, conv_en SHALL be 1 and the address outputs SHALL stay constant. STOP=1 SHALL move the block to NEXT.
REQ-012 NEXT SHALL last one cycle with conv_en=0, so conv_en is low for at least 2 cycles between passes and the engine re-initialises.
REQ-013 NEXT SHALL advance the counters as follows:
- if lvl < n_in: lvl+1, go to SETUP
- else if num < n_filt: lvl=0, num+1, go to SETUP
- else: go to FIN
REQ-014 FIN SHALL pulse done for exactly one cycle and then return to IDLE. lvl and num SHALL hold their final values in IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 A layer SHALL run exactly (n_in+1)*(n_filt+1) passes, in order lvl-inner, num-outer.
REQ-017 The watchdog SHALL clear on entry to RUN and increment each RUN cycle. At all-ones without STOP it SHALL set timeout_err, drop conv_en and go to IDLE with no done pulse.
REQ-018 timeout_err SHALL be sticky until the next accepted start or reset.
REQ-019 abort=1 in any non-IDLE state SHALL drop conv_en and go to IDLE on the next edge, with no done pulse. abort SHALL take priority over STOP and over a watchdog expiry in the same cycle.
REQ-020 STOP=1 outside RUN SHALL be ignored.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 rst_n=0 SHALL force state IDLE immediately, independent of clk.
REQ-023 rst_n=0 SHALL clear conv_en, busy, done, timeout_err, bias, lvl, num, filt, memstartp, memstartw, memstartzap and the watchdog to 0.
REQ-024 Reset asserted mid-layer SHALL drop conv_en immediately. After release the block SHALL wait for a new start.

Verification
REQ-025 Single pass: n_in=0, n_filt=0, base_p=100, base_w=5, base_zap=900, matrix2=784, STOP 10 cycles after conv_en rises -> memstartp=100, memstartw=5, memstartzap=900, bias=1, one done pulse, busy falls the cycle after done.
REQ-026 Full sweep: n_in=2, n_filt=1, matrix2=196, base_p=0, base_w=0, base_zap=1000 -> 6 passes with (lvl,num,memstartp,memstartw,memstartzap) = (0,0,0,0,1000), (1,0,196,1,1000), (2,0,392,2,1000), (0,1,0,3,1196), (1,1,196,4,1196), (2,1,392,5,1196); bias=1 only on passes 3 and 6; conv_en low at least 2 cycles between passes.
REQ-027 Abort: assert abort together with STOP during pass 2 of REQ-026 -> conv_en=0 next cycle, state IDLE, done never pulses; a later start runs all 6 passes again from lvl=0, num=0.
REQ-028 Watchdog: TIMEOUT_W=4, STOP never asserted -> conv_en drops after 15 RUN cycles, timeout_err=1 and stays 1 until the next start.
REQ-029 Wrap and ignore: base_p=8190, matrix2=4, n_in=1 (SIZE_address_pix=13) -> second pass memstartp=2. start pulsed while busy and STOP pulsed in IDLE -> no effect.
REQ-030 Async reset: drop rst_n mid-RUN between clock edges -> conv_en, busy and lvl read 0 before the next clk edge.

Source files
------------

// File: rtl/conv_layer_seq.sv
// Layer sequencer for a convolution engine: walks input channels (inner) and
// filters (outer), issuing one engine pass per (lvl, num) pair with its start addresses.
module conv_layer_seq #(
  parameter int SIZE_address_pix = 13,
  parameter int SIZE_address_wei = 13,
  parameter int TIMEOUT_W        = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [3:0]                  n_in,
  input  logic [2:0]                  n_filt,
  input  logic [9:0]                  matrix2,
  input  logic [SIZE_address_pix-1:0] base_p,
  input  logic [SIZE_address_wei-1:0] base_w,
  input  logic [SIZE_address_pix-1:0] base_zap,
  input  logic                        STOP,
  output logic                        conv_en,
  output logic [SIZE_address_pix-1:0] memstartp,
  output logic [SIZE_address_pix-1:0] memstartzap,
  output logic [SIZE_address_wei-1:0] memstartw,
  output logic [3:0]                  lvl,
  output logic [2:0]                  num,
  output logic [2:0]                  filt,
  output logic                        bias,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout_err
);
  localparam int PW = SIZE_address_pix;
  localparam int WW = SIZE_address_wei;
  // Expiry fires on the RUN cycle that steps the counter to all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {IDLE, SETUP, RUN, NEXT, FIN} state_t;

  typedef struct packed {
    logic [3:0]    n_in;
    logic [2:0]    n_filt;
    logic [9:0]    matrix2;
    logic [PW-1:0] base_p;
    logic [WW-1:0] base_w;
    logic [PW-1:0] base_zap;
  } cfg_t;

  state_t               state, nxt;
  cfg_t                 cfg, cfg_d;
  logic [3:0]           lvl_d;
  logic [2:0]           num_d;
  logic [TIMEOUT_W-1:0] wdog;
  logic                 accept, expire;
  logic                 conv_en_d, busy_d, done_d;
  logic [PW-1:0]        p_d, zap_d;
  logic [WW-1:0]        w_d, ch_cnt;

  assign accept = (state == IDLE) && start;
  assign expire = (state == RUN) && !STOP && (wdog == WD_LAST);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = SETUP;
      SETUP:   nxt = RUN;
      RUN:     if (STOP) nxt = NEXT; else if (expire) nxt = IDLE;
      NEXT:    nxt = (lvl < cfg.n_in || num < cfg.n_filt) ? SETUP : FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE) nxt = IDLE;
  end

  // Next values of the registered outputs; addresses use the post-update counters
  // so they and bias are already valid during SETUP.
  always_comb begin
    cfg_d = cfg;
    lvl_d = lvl;
    num_d = num;
    if (accept) begin
      cfg_d.n_in     = n_in;
      cfg_d.n_filt   = n_filt;
      cfg_d.matrix2  = matrix2;
      cfg_d.base_p   = base_p;
      cfg_d.base_w   = base_w;
      cfg_d.base_zap = base_zap;
      lvl_d = '0;
      num_d = '0;
    end
    if (state == NEXT && !abort) begin
      if (lvl < cfg.n_in) lvl_d = lvl + 4'd1;
      else if (num < cfg.n_filt) begin
        lvl_d = '0;
        num_d = num + 3'd1;
      end
    end
    conv_en_d = (nxt == RUN);
    busy_d    = (nxt != IDLE);
    done_d    = (nxt == FIN);
    ch_cnt    = WW'(cfg_d.n_in) + WW'(1);
    p_d       = cfg_d.base_p + PW'(lvl_d) * PW'(cfg_d.matrix2);
    w_d       = cfg_d.base_w + WW'(num_d) * ch_cnt + WW'(lvl_d);
    zap_d     = cfg_d.base_zap + PW'(num_d) * PW'(cfg_d.matrix2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg         <= '0;
      lvl         <= '0;
      num         <= '0;
      filt        <= '0;
      conv_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bias        <= 1'b0;
      timeout_err <= 1'b0;
      memstartp   <= '0;
      memstartw   <= '0;
      memstartzap <= '0;
      wdog        <= '0;
    end else begin
      cfg     <= cfg_d;
      lvl     <= lvl_d;
      num     <= num_d;
      conv_en <= conv_en_d;
      busy    <= busy_d;
      done    <= done_d;
      if (accept) begin
        filt        <= n_filt;
        timeout_err <= 1'b0;
      end else if (expire && !abort) begin
        timeout_err <= 1'b1;
      end
      if (nxt == SETUP) begin
        memstartp   <= p_d;
        memstartw   <= w_d;
        memstartzap <= zap_d;
        bias        <= (lvl_d == cfg_d.n_in);
      end
      wdog <= (state == RUN) ? wdog + TIMEOUT_W'(1) : '0;
    end
  end
endmodule

// File: tb/tb_conv_layer_seq.sv
// Scoreboard bench for conv_layer_seq: expected passes queued at start, checked as each pass begins.
`timescale 1ns/1ps
module tb_conv_layer_seq;
  localparam int PW = 13;
  localparam int WW = 13;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, STOP = 1'b0;
  logic [3:0]    n_in = '0;
  logic [2:0]    n_filt = '0;
  logic [9:0]    matrix2 = '0;
  logic [PW-1:0] base_p = '0, base_zap = '0;
  logic [WW-1:0] base_w = '0;
  logic          conv_en, bias, busy, done, timeout_err;
  logic [PW-1:0] memstartp, memstartzap;
  logic [WW-1:0] memstartw;
  logic [3:0]    lvl;
  logic [2:0]    num, filt;

  conv_layer_seq #(.SIZE_address_pix(PW), .SIZE_address_wei(WW), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .n_in(n_in), .n_filt(n_filt), .matrix2(matrix2),
    .base_p(base_p), .base_w(base_w), .base_zap(base_zap), .STOP(STOP),
    .conv_en(conv_en), .memstartp(memstartp), .memstartzap(memstartzap), .memstartw(memstartw),
    .lvl(lvl), .num(num), .filt(filt), .bias(bias),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { int lvl; int num; int p; int w; int zap; int bias; } pass_t;
  pass_t sb[$];
  int n_cmp = 0, n_err = 0, done_cnt = 0, gap = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push_layer(input int ni, nf, m2, bp, bw, bz);
    pass_t e;
    for (int f = 0; f <= nf; f++)
      for (int c = 0; c <= ni; c++) begin
        e.lvl = c; e.num = f;
        e.p   = (bp + c * m2) % 8192;
        e.w   = (bw + f * (ni + 1) + c) % 8192;
        e.zap = (bz + f * m2) % 8192;
        e.bias = (c == ni) ? 1 : 0;
        sb.push_back(e);
      end
  endtask

  task automatic start_layer(input int ni, nf, m2, bp, bw, bz);
    n_in = 4'(ni); n_filt = 3'(nf); matrix2 = 10'(m2);
    base_p = PW'(bp); base_w = WW'(bw); base_zap = PW'(bz);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("setup_busy", busy, 1);
    chk("setup_conv_en", conv_en, 0);
    chk("filt", filt, nf);
    chk("err_clear", timeout_err, 0);
    n_in = 4'($urandom); n_filt = 3'($urandom); matrix2 = 10'($urandom);
    base_p = PW'($urandom); base_w = WW'($urandom); base_zap = PW'($urandom);
    gap = 99;
  endtask

  task automatic wait_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (conv_en === 1'b1) begin ok = 1'b1; break; end
      gap++;
      tick;
    end
    if (!ok) chk("conv_en_rise_timeout", 0, 1);
  endtask

  task automatic check_pass;
    pass_t e;
    if (sb.size() == 0) begin chk("sb_empty", 0, 1); return; end
    e = sb.pop_front();
    chk("lvl", lvl, e.lvl);
    chk("num", num, e.num);
    chk("memstartp", memstartp, e.p);
    chk("memstartw", memstartw, e.w);
    chk("memstartzap", memstartzap, e.zap);
    chk("bias", bias, e.bias);
    chk("gap_ge2", gap >= 2, 1);
  endtask

  task automatic finish_pass(input int dly);
    repeat (dly - 1) tick;
    chk("run_hold", conv_en, 1);
    STOP = 1'b1;
    tick;
    STOP = 1'b0;
    chk("stop_drop", conv_en, 0);
    gap = 1;
  endtask

  task automatic run_layer(input int ni, nf, m2, bp, bw, bz, dly, poke);
    int d0, idx;
    bit ok;
    push_layer(ni, nf, m2, bp, bw, bz);
    start_layer(ni, nf, m2, bp, bw, bz);
    d0 = done_cnt;
    idx = 0;
    while (sb.size() > 0) begin
      wait_rise(ok);
      if (!ok) begin sb.delete(); break; end
      check_pass;
      if (poke != 0 && idx == 0) begin
        start = 1'b1; n_in = 4'($urandom);
        tick;
        start = 1'b0;
        chk("poke_busy", busy, 1);
        chk("poke_lvl", lvl, 0);
      end
      finish_pass(dly);
      idx++;
    end
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) break;
      tick;
    end
    chk("done", done, 1);
    tick;
    chk("done_drop", done, 0);
    chk("busy_fall", busy, 0);
    chk("done_once", done_cnt - d0, 1);
    chk("final_lvl", lvl, ni);
    chk("final_num", num, nf);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int d0, hi;
    bit ok;
    #23;
    chk("rst_conv_en", conv_en, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0); chk("rst_bias", bias, 0); chk("rst_lvl", lvl, 0);
    chk("rst_num", num, 0); chk("rst_filt", filt, 0); chk("rst_p", memstartp, 0);
    chk("rst_w", memstartw, 0); chk("rst_zap", memstartzap, 0);
    rst_n = 1'b1;
    tick;

    run_layer(0, 0, 784, 100, 5, 900, 10, 0);
    run_layer(2, 1, 196, 0, 0, 1000, 3, 0);

    // Abort with STOP in the same cycle during pass 2
    push_layer(2, 1, 196, 0, 0, 1000);
    start_layer(2, 1, 196, 0, 0, 1000);
    wait_rise(ok); check_pass; finish_pass(3);
    wait_rise(ok); check_pass;
    d0 = done_cnt;
    abort = 1'b1; STOP = 1'b1;
    tick;
    abort = 1'b0; STOP = 1'b0;
    chk("abort_conv_en", conv_en, 0);
    chk("abort_busy", busy, 0);
    repeat (5) tick;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", busy, 0);
    sb.delete();
    run_layer(2, 1, 196, 0, 0, 1000, 2, 0);

    // Watchdog expiry
    push_layer(0, 0, 10, 1, 2, 3);
    start_layer(0, 0, 10, 1, 2, 3);
    d0 = done_cnt;
    wait_rise(ok); check_pass;
    hi = 0;
    while (conv_en === 1'b1 && hi < 40) begin hi++; tick; end
    chk("wd_cycles", hi, 15);
    chk("wd_err", timeout_err, 1);
    chk("wd_busy", busy, 0);
    repeat (3) tick;
    chk("wd_sticky", timeout_err, 1);
    chk("wd_no_done", done_cnt - d0, 0);

    // Address wrap plus start ignored while busy, then STOP ignored in IDLE
    run_layer(1, 0, 4, 8190, 7, 8000, 4, 1);
    STOP = 1'b1;
    tick; tick;
    STOP = 1'b0;
    tick;
    chk("idle_stop_busy", busy, 0);
    chk("idle_stop_conv_en", conv_en, 0);

    // Asynchronous reset mid-RUN
    push_layer(2, 1, 196, 0, 0, 1000);
    start_layer(2, 1, 196, 0, 0, 1000);
    wait_rise(ok); check_pass; finish_pass(3);
    wait_rise(ok); check_pass;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_conv_en", conv_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_lvl", lvl, 0);
    chk("arst_p", memstartp, 0);
    #2 rst_n = 1'b1;
    sb.delete();
    repeat (5) tick;
    chk("arst_wait_busy", busy, 0);
    chk("arst_wait_conv_en", conv_en, 0);

    run_layer(1, 1, 50, 10, 20, 30, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
